// File: rtl/pc_sequencer_pkg.sv
// Shared types and sizing helpers for the program-counter sequencer.
// The optional return-address stack is enabled with the PC_CALL_STACK_EN macro.
package pc_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pc_state_e;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_PHASES      = 4;
  localparam int DEF_OFF_W       = 8;
  localparam int DEF_STACK_DEPTH = 4;

  // Phase index width; never narrower than one bit.
  function automatic int phase_w(input int phases);
    return (phases <= 2) ? 1 : $clog2(phases);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/status bundle between the control unit (master) and the PC sequencer (slave).
// stack_err only carries information when PC_CALL_STACK_EN is defined.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OFF_W  = DEF_OFF_W,
  parameter int PH_W   = phase_w(DEF_PHASES)
);
  logic              start;
  logic              halt;
  logic              stall;
  logic              load;
  logic              inc;
  logic              rel;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] c_bus;
  logic [OFF_W-1:0]  offset;
  logic [ADDR_W-1:0] ins_address;
  logic [PH_W-1:0]   phase;
  logic              commit;
  logic              running;
  logic              stack_err;

  modport master (
    output start, halt, stall, load, inc, rel, call, ret, c_bus, offset,
    input  ins_address, phase, commit, running, stack_err
  );

  modport slave (
    input  start, halt, stall, load, inc, rel, call, ret, c_bus, offset,
    output ins_address, phase, commit, running, stack_err
  );
endinterface

// File: rtl/pc_return_stack.sv
// Pointer-based LIFO of return addresses; only instantiated when PC_CALL_STACK_EN is defined.
// Push while full and pop while empty are dropped; the caller flags the error.
module pc_return_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] top
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign top   = mem[IDX_W'(count - CNT_W'(1))];

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[IDX_W'(count)] <= din;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Parametrised program counter with a PHASES-cycle instruction sequencer.
// Define PC_CALL_STACK_EN to add the call/return stack; otherwise call acts as load and ret is ignored.
//
//   state   | meaning
//   ST_IDLE | stopped, phase held at 0, waiting for start
//   ST_RUN  | stepping phases; address updates on the commit cycle
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               ADDR_W      = DEF_ADDR_W,
  parameter int               PHASES      = DEF_PHASES,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int               OFF_W       = DEF_OFF_W,
  parameter int               STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  pc_sequencer_if.slave  bus
);
  localparam int              PH_W    = phase_w(PHASES);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);
  localparam int              SUM_W   = (ADDR_W > OFF_W) ? ADDR_W : OFF_W;

  pc_state_e         state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] next_addr, addr_inc, addr_rel;
  logic [SUM_W-1:0]  off_ext;
  logic              advance, commit, take_load;

  assign advance  = (state_q == ST_RUN) && enable && !bus.stall;
  assign commit   = advance && (phase_q == PH_LAST);
  assign addr_inc = addr_q + ADDR_W'(1);
  assign off_ext  = SUM_W'($signed(bus.offset));
  assign addr_rel = addr_q + off_ext[ADDR_W-1:0];

`ifdef PC_CALL_STACK_EN
  logic              push, pop, err_set, err_q;
  logic              stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_top;

  assign take_load = bus.load;

  pc_return_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (addr_inc),
    .full  (stk_full),
    .empty (stk_empty),
    .top   (stk_top)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign bus.stack_err = err_q;
`else
  logic unused_ret;

  assign take_load     = bus.load | bus.call;
  assign unused_ret    = bus.ret;
  assign bus.stack_err = 1'b0;
`endif

  // Next address if this cycle commits; priority ret > call > load > rel > inc.
  always_comb begin
    next_addr = addr_q;
`ifdef PC_CALL_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (bus.ret) begin
      if (stk_empty) begin
        next_addr = addr_inc;
        err_set   = commit;
      end else begin
        next_addr = stk_top;
        pop       = commit;
      end
    end else if (bus.call) begin
      if (stk_full) begin
        next_addr = addr_inc;
        err_set   = commit;
      end else begin
        next_addr = bus.c_bus;
        push      = commit;
      end
    end else
`endif
    if (take_load) begin
      next_addr = bus.c_bus;
    end else if (bus.rel) begin
      next_addr = addr_rel;
    end else if (bus.inc) begin
      next_addr = addr_inc;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (enable && bus.start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (advance) begin
          if (commit) begin
            phase_d = '0;
            addr_d  = next_addr;
            if (bus.halt) state_d = ST_IDLE;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      addr_q  <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.ins_address = addr_q;
  assign bus.phase       = phase_q;
  assign bus.commit      = commit;
  assign bus.running     = (state_q == ST_RUN);
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model (PC_CALL_STACK_EN aware).
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int              ADDR_W      = 8;
  localparam int              PHASES      = 4;
  localparam int              OFF_W       = 8;
  localparam int              STACK_DEPTH = 2;
  localparam logic [ADDR_W-1:0] RESET_ADDR = 8'h00;
  localparam int              PH_W        = phase_w(PHASES);
  localparam int              AMOD        = 1 << ADDR_W;

  logic clk, reset, enable;

  pc_sequencer_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .PH_W(PH_W)) bus();

  pc_sequencer #(
    .ADDR_W      (ADDR_W),
    .PHASES      (PHASES),
    .RESET_ADDR  (RESET_ADDR),
    .OFF_W       (OFF_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: instruction-level view of the sequencer.
  bit m_run = 1'b0;
  int m_ph = 0;
  int m_addr = int'(RESET_ADDR);
  bit m_err = 1'b0;
  int stk[$];
  bit chk_on = 1'b0;

  function automatic int model_next();
    int inc1 = (m_addr + 1) % AMOD;
    int off = int'(bus.offset);
    if (off >= (1 << (OFF_W - 1))) off -= (1 << OFF_W);
`ifdef PC_CALL_STACK_EN
    if (bus.ret) begin
      if (stk.size() == 0) begin
        m_err = 1'b1;
        return inc1;
      end
      return stk.pop_back();
    end
    if (bus.call) begin
      if (stk.size() == STACK_DEPTH) begin
        m_err = 1'b1;
        return inc1;
      end
      stk.push_back(inc1);
      return int'(bus.c_bus);
    end
`else
    if (bus.call) return int'(bus.c_bus);
`endif
    if (bus.load) return int'(bus.c_bus);
    if (bus.rel)  return ((m_addr + off) % AMOD + AMOD) % AMOD;
    if (bus.inc)  return inc1;
    return m_addr;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_run  = 1'b0;
      m_ph   = 0;
      m_addr = int'(RESET_ADDR);
      m_err  = 1'b0;
      stk.delete();
    end else if (enable) begin
      if (!m_run) begin
        if (bus.start) m_run = 1'b1;
      end else if (!bus.stall) begin
        if (m_ph == PHASES - 1) begin
          m_ph   = 0;
          m_addr = model_next();
          if (bus.halt) m_run = 1'b0;
        end else begin
          m_ph++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("ins_address", 32'(bus.ins_address), 32'(m_addr));
      check("phase",       32'(bus.phase),       32'(m_ph));
      check("running",     32'(bus.running),     32'(m_run));
      check("commit",      32'(bus.commit),
            32'(m_run && enable && !bus.stall && (m_ph == PHASES - 1)));
      check("stack_err",   32'(bus.stack_err),   32'(m_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    bus.start = 1'b0; bus.halt = 1'b0; bus.stall = 1'b0;
    bus.load = 1'b0;  bus.inc = 1'b0;  bus.rel = 1'b0;
    bus.call = 1'b0;  bus.ret = 1'b0;
    bus.c_bus = '0;   bus.offset = '0;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    clear_req();
    tick(2);
    chk_on = 1'b1;
    check("rst_addr", 32'(bus.ins_address), 32'h00);
    check("rst_running", 32'(bus.running), 32'h0);
    check("rst_phase", 32'(bus.phase), 32'h0);

    // start with inc held: one commit every PHASES cycles
    reset = 1'b0; bus.inc = 1'b1; bus.start = 1'b1;
    tick(1); bus.start = 1'b0;
    check("run_entry", 32'(bus.running), 32'h1);
    tick(3);
    check("first_commit", 32'(bus.commit), 32'h1);
    check("first_commit_addr", 32'(bus.ins_address), 32'h00);
    tick(1); check("inc_1", 32'(bus.ins_address), 32'h01);
    tick(4); check("inc_2", 32'(bus.ins_address), 32'h02);
    tick(4); check("inc_3", 32'(bus.ins_address), 32'h03);

    // wrap through all-ones
    bus.inc = 1'b0; bus.load = 1'b1; bus.c_bus = 8'hFE;
    tick(4); check("load_fe", 32'(bus.ins_address), 32'hFE);
    bus.load = 1'b0; bus.inc = 1'b1;
    tick(4); check("wrap_ff", 32'(bus.ins_address), 32'hFF);
    tick(4); check("wrap_00", 32'(bus.ins_address), 32'h00);
    tick(4); check("wrap_01", 32'(bus.ins_address), 32'h01);

    // relative branch and load-over-rel priority
    bus.inc = 1'b0; bus.load = 1'b1; bus.c_bus = 8'h10;
    tick(4); check("load_10", 32'(bus.ins_address), 32'h10);
    bus.load = 1'b0; bus.rel = 1'b1; bus.offset = 8'hFC;
    tick(4); check("rel_m4", 32'(bus.ins_address), 32'h0C);
    bus.load = 1'b1; bus.c_bus = 8'h80;
    tick(4); check("load_beats_rel", 32'(bus.ins_address), 32'h80);
    bus.load = 1'b0; bus.rel = 1'b0; bus.inc = 1'b1;

    // stall at phase 2 for 3 cycles
    tick(2);
    bus.stall = 1'b1;
    tick(3);
    check("stall_phase", 32'(bus.phase), 32'h2);
    check("stall_addr", 32'(bus.ins_address), 32'h80);
    check("stall_commit", 32'(bus.commit), 32'h0);
    bus.stall = 1'b0;
    tick(1); check("post_stall_commit", 32'(bus.commit), 32'h1);
    tick(1); check("post_stall_addr", 32'(bus.ins_address), 32'h81);

    // reset mid-instruction
    tick(1);
    reset = 1'b1;
    tick(1);
    check("midrst_addr", 32'(bus.ins_address), 32'(RESET_ADDR));
    check("midrst_running", 32'(bus.running), 32'h0);
    reset = 1'b0;

    // halt at commit, then restart from held address
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
    bus.halt = 1'b1;
    tick(3); check("halt_commit", 32'(bus.commit), 32'h1);
    tick(1);
    check("halt_running", 32'(bus.running), 32'h0);
    check("halt_phase", 32'(bus.phase), 32'h0);
    check("halt_addr", 32'(bus.ins_address), 32'h01);
    bus.halt = 1'b0;
    tick(3); check("idle_hold", 32'(bus.ins_address), 32'h01);
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
    tick(4); check("restart_addr", 32'(bus.ins_address), 32'h02);

    // global enable freeze
    tick(2);
    enable = 1'b0;
    tick(3);
    check("en_phase", 32'(bus.phase), 32'h2);
    check("en_commit", 32'(bus.commit), 32'h0);
    enable = 1'b1;
    tick(2); check("en_resume", 32'(bus.ins_address), 32'h03);

    // call/return
    bus.inc = 1'b0; bus.load = 1'b1; bus.c_bus = 8'h05;
    tick(4); check("load_05", 32'(bus.ins_address), 32'h05);
    bus.load = 1'b0; bus.call = 1'b1; bus.c_bus = 8'h40;
    tick(4); check("call_40", 32'(bus.ins_address), 32'h40);
    bus.c_bus = 8'h60;
    tick(4); check("call_60", 32'(bus.ins_address), 32'h60);
    bus.c_bus = 8'h70;
    tick(4);
`ifdef PC_CALL_STACK_EN
    check("call_full", 32'(bus.ins_address), 32'h61);
    check("call_full_err", 32'(bus.stack_err), 32'h1);
`else
    check("call_as_load", 32'(bus.ins_address), 32'h70);
    check("err_tied", 32'(bus.stack_err), 32'h0);
`endif
    bus.call = 1'b0; bus.ret = 1'b1;
    tick(4);
`ifdef PC_CALL_STACK_EN
    check("ret_1", 32'(bus.ins_address), 32'h41);
    tick(4); check("ret_2", 32'(bus.ins_address), 32'h06);
    tick(4); check("ret_empty", 32'(bus.ins_address), 32'h07);
    check("ret_empty_err", 32'(bus.stack_err), 32'h1);
`else
    check("ret_ignored", 32'(bus.ins_address), 32'h70);
`endif
    clear_req();

    // randomized traffic; the negedge compare checks every cycle
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      enable     = ($urandom_range(0, 7) != 0);
      bus.start  = ($urandom_range(0, 9) == 0);
      bus.halt   = ($urandom_range(0, 19) == 0);
      bus.stall  = ($urandom_range(0, 4) == 0);
      bus.load   = ($urandom_range(0, 3) == 0);
      bus.inc    = ($urandom_range(0, 1) == 0);
      bus.rel    = ($urandom_range(0, 3) == 0);
      bus.call   = ($urandom_range(0, 5) == 0);
      bus.ret    = ($urandom_range(0, 5) == 0);
      bus.c_bus  = ADDR_W'($urandom);
      bus.offset = OFF_W'($urandom);
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
